// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle RV32 control FSM: state codes and trap causes.
package multicycle_ctrl_fsm_pkg;

    // 3-bit state encoding; codes 6 and 7 are unused and recover to ST_IF
    typedef enum logic [2:0] {
        ST_IF    = 3'd0,
        ST_ID_EX = 3'd1,
        ST_MEM   = 3'd2,
        ST_WB    = 3'd3,
        ST_HALT  = 3'd4,
        ST_TRAP  = 3'd5
    } state_e;

    // Trap cause codes reported on trap_cause
    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_IMEM_TO = 2'b10;
    localparam logic [1:0] TRAP_DMEM_TO = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_fsm_mem_wait_timer.sv
// Wait-cycle counter shared by the IF and MEM states. Counts cycles spent
// waiting for a ready and flags when the count equals MEM_TIMEOUT.
// MEM_TIMEOUT = 0 disables the hit output entirely.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [CW-1:0] count_reg;

    // Wait counter: clear has priority over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign hit = (MEM_TIMEOUT != 0) && (count_reg == CW'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32 control FSM: IF -> ID_EX -> [MEM] -> WB, with IMEM/DMEM
// ready handshakes, bounded wait timeout, illegal-decode trap and HALT/resume.
// Enables are a combinational decode of state and decoder flags, forced to 0
// while rst is high; trap_cause and the counters are registered.
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 is_LUI,
    input  logic                 is_AUIPC,
    input  logic                 is_JAL,
    input  logic                 is_JALR,
    input  logic                 is_IMM,
    input  logic                 is_ALU,
    input  logic                 is_LOAD,
    input  logic                 is_STORE,
    input  logic                 is_BRANCH,
    input  logic                 is_FENCE,
    input  logic                 is_SYSTEM,
    input  logic [XLEN/8-1:0]    decoder_dmem_we,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    input  logic                 resume,
    output logic                 pc_we,
    output logic                 imem_rd,
    output logic                 rf_we,
    output logic                 dmem_rd,
    output logic [XLEN/8-1:0]    dmem_we,
    output logic                 halted,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     instret_cnt
);

    localparam int BE_W = XLEN / 8;

    state_e            state_reg;
    state_e            state_next;
    logic [1:0]        trap_cause_reg;
    logic [1:0]        trap_cause_next;
    logic [CNT_W-1:0]  cycle_cnt_reg;
    logic [CNT_W-1:0]  instret_cnt_reg;
    logic              wb_from_halt_reg;

    logic              tmr_clr;
    logic              tmr_inc;
    logic              tmr_hit;

    logic              pc_we_next;
    logic              imem_rd_next;
    logic              rf_we_next;
    logic              dmem_rd_next;
    logic [BE_W-1:0]   dmem_we_next;
    logic              halted_next;
    logic              trap_next;

    logic              any_flag;

    assign any_flag = is_LUI | is_AUIPC | is_JAL | is_JALR | is_IMM | is_ALU |
                      is_LOAD | is_STORE | is_BRANCH | is_FENCE | is_SYSTEM;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .inc (tmr_inc),
        .hit (tmr_hit)
    );

    // State register plus the marker that the upcoming WB retires a halted SYSTEM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_IF;
            wb_from_halt_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            wb_from_halt_reg <= (state_reg == ST_HALT) && resume;
        end
    end

    // Next-state, enable decode and wait-timer control
    always_comb begin
        state_next      = state_reg;
        trap_cause_next = TRAP_NONE;
        tmr_clr         = 1'b1;
        tmr_inc         = 1'b0;
        pc_we_next      = 1'b0;
        imem_rd_next    = 1'b0;
        rf_we_next      = 1'b0;
        dmem_rd_next    = 1'b0;
        dmem_we_next    = '0;
        halted_next     = 1'b0;
        trap_next       = 1'b0;

        case (state_reg)
            ST_IF: begin
                imem_rd_next = 1'b1;
                if (imem_ready) begin
                    state_next = ST_ID_EX;
                end else if (tmr_hit) begin
                    state_next      = ST_TRAP;
                    trap_cause_next = TRAP_IMEM_TO;
                end else begin
                    tmr_clr = 1'b0;
                    tmr_inc = 1'b1;
                end
            end
            ST_ID_EX: begin
                if (is_SYSTEM) begin
                    state_next = ST_HALT;
                end else if (is_LOAD || is_STORE) begin
                    state_next = ST_MEM;
                end else if (!any_flag) begin
                    state_next      = ST_TRAP;
                    trap_cause_next = TRAP_ILLEGAL;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_rd_next = is_LOAD;
                dmem_we_next = is_STORE ? decoder_dmem_we : '0;
                if (dmem_ready) begin
                    state_next = ST_WB;
                end else if (tmr_hit) begin
                    state_next      = ST_TRAP;
                    trap_cause_next = TRAP_DMEM_TO;
                end else begin
                    tmr_clr = 1'b0;
                    tmr_inc = 1'b1;
                end
            end
            ST_WB: begin
                pc_we_next = 1'b1;
                rf_we_next = !wb_from_halt_reg &&
                             !(is_STORE | is_BRANCH | is_FENCE | is_SYSTEM);
                state_next = ST_IF;
            end
            ST_HALT: begin
                halted_next = 1'b1;
                if (resume) begin
                    state_next = ST_WB;
                end
            end
            ST_TRAP: begin
                trap_next = 1'b1;
            end
            default: begin
                state_next = ST_IF;
            end
        endcase
    end

    // Trap cause latches on entry to TRAP and holds until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_cause_reg <= TRAP_NONE;
        end else if ((state_next == ST_TRAP) && (state_reg != ST_TRAP)) begin
            trap_cause_reg <= trap_cause_next;
        end
    end

    // Cycle counter (frozen in HALT/TRAP) and retired-instruction counter (WB)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_reg   <= '0;
            instret_cnt_reg <= '0;
        end else begin
            if ((state_reg != ST_HALT) && (state_reg != ST_TRAP)) begin
                cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
            end
            if (state_reg == ST_WB) begin
                instret_cnt_reg <= instret_cnt_reg + CNT_W'(1);
            end
        end
    end

    // Requests drop the instant rst rises, without waiting for a clock
    assign pc_we       = pc_we_next   & ~rst;
    assign imem_rd     = imem_rd_next & ~rst;
    assign rf_we       = rf_we_next   & ~rst;
    assign dmem_rd     = dmem_rd_next & ~rst;
    assign dmem_we     = dmem_we_next & {BE_W{~rst}};
    assign halted      = halted_next  & ~rst;
    assign trap        = trap_next    & ~rst;
    assign trap_cause  = trap_cause_reg;
    assign cycle_cnt   = cycle_cnt_reg;
    assign instret_cnt = instret_cnt_reg;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm (MEM_TIMEOUT = 8). Inputs change and
// outputs are sampled 1-2 time units after each rising edge.
module tb_multicycle_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        is_LUI = 0, is_AUIPC = 0, is_JAL = 0, is_JALR = 0, is_IMM = 0, is_ALU = 0;
    logic        is_LOAD = 0, is_STORE = 0, is_BRANCH = 0, is_FENCE = 0, is_SYSTEM = 0;
    logic [3:0]  decoder_dmem_we = 4'b0000;
    logic        imem_ready = 0, dmem_ready = 0, resume = 0;
    logic        pc_we, imem_rd, rf_we, dmem_rd, halted, trap;
    logic [3:0]  dmem_we;
    logic [1:0]  trap_cause;
    logic [31:0] cycle_cnt, instret_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(
        .XLEN        (32),
        .MEM_TIMEOUT (8),
        .CNT_W       (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .is_LUI          (is_LUI),
        .is_AUIPC        (is_AUIPC),
        .is_JAL          (is_JAL),
        .is_JALR         (is_JALR),
        .is_IMM          (is_IMM),
        .is_ALU          (is_ALU),
        .is_LOAD         (is_LOAD),
        .is_STORE        (is_STORE),
        .is_BRANCH       (is_BRANCH),
        .is_FENCE        (is_FENCE),
        .is_SYSTEM       (is_SYSTEM),
        .decoder_dmem_we (decoder_dmem_we),
        .imem_ready      (imem_ready),
        .dmem_ready      (dmem_ready),
        .resume          (resume),
        .pc_we           (pc_we),
        .imem_rd         (imem_rd),
        .rf_we           (rf_we),
        .dmem_rd         (dmem_rd),
        .dmem_we         (dmem_we),
        .halted          (halted),
        .trap            (trap),
        .trap_cause      (trap_cause),
        .cycle_cnt       (cycle_cnt),
        .instret_cnt     (instret_cnt)
    );

    task automatic clear_inputs();
        {is_LUI, is_AUIPC, is_JAL, is_JALR, is_IMM, is_ALU} = '0;
        {is_LOAD, is_STORE, is_BRANCH, is_FENCE, is_SYSTEM} = '0;
        decoder_dmem_we = 4'b0000;
        imem_ready = 0;
        dmem_ready = 0;
        resume = 0;
    endtask

    // Advance to 1 unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset for one clock; returns in cycle c1 (state IF)
    task automatic reset_dut();
        step();
        rst = 1'b1;
        clear_inputs();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        step();
        rst = 1'b1;
        clear_inputs();
        is_ALU = 1'b1;
        imem_ready = 1'b1;
        #1;
        checks++;
        if ({pc_we, imem_rd, rf_we, dmem_rd, dmem_we, halted, trap, trap_cause} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0",
                     {pc_we, imem_rd, rf_we, dmem_rd, dmem_we, halted, trap, trap_cause});
        end
        checks++;
        if ({cycle_cnt, instret_cnt} !== 64'd0) begin
            errors++;
            $display("FAIL reset_counters got %0d/%0d exp 0/0", cycle_cnt, instret_cnt);
        end
        step();
        step();
        checks++;
        if (imem_rd !== 1'b0 || cycle_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_held got imem_rd=%0b cyc=%0d exp 0/0", imem_rd, cycle_cnt);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (imem_rd !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_imem_rd got %0b exp 1", imem_rd);
        end
        $display("test_reset done");
    endtask

    task automatic test_alu();
        reset_dut();
        is_ALU = 1'b1;
        imem_ready = 1'b1;
        #1;
        checks++;
        if (imem_rd !== 1'b1 || pc_we !== 1'b0) begin
            errors++;
            $display("FAIL alu_c1 got imem_rd=%0b pc_we=%0b exp 1/0", imem_rd, pc_we);
        end
        step();
        checks++;
        if ({imem_rd, pc_we, rf_we} !== 3'b000) begin
            errors++;
            $display("FAIL alu_c2 got %b exp 000", {imem_rd, pc_we, rf_we});
        end
        step();
        checks++;
        if (pc_we !== 1'b1 || rf_we !== 1'b1 || imem_rd !== 1'b0) begin
            errors++;
            $display("FAIL alu_c3_wb got pc_we=%0b rf_we=%0b imem_rd=%0b exp 1/1/0", pc_we, rf_we, imem_rd);
        end
        step();
        checks++;
        if (instret_cnt !== 32'd1 || cycle_cnt !== 32'd3 || imem_rd !== 1'b1) begin
            errors++;
            $display("FAIL alu_after got instret=%0d cyc=%0d imem_rd=%0b exp 1/3/1", instret_cnt, cycle_cnt, imem_rd);
        end
        $display("test_alu done");
    endtask

    task automatic test_back_to_back();
        reset_dut();
        is_IMM = 1'b1;
        imem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (pc_we !== ((i % 3) == 2) || imem_rd !== ((i % 3) == 0)) begin
                errors++;
                $display("FAIL b2b_c%0d got pc_we=%0b imem_rd=%0b", i + 1, pc_we, imem_rd);
            end
            step();
        end
        checks++;
        if (instret_cnt !== 32'd2 || cycle_cnt !== 32'd6) begin
            errors++;
            $display("FAIL b2b_counters got instret=%0d cyc=%0d exp 2/6", instret_cnt, cycle_cnt);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_store();
        reset_dut();
        is_STORE = 1'b1;
        decoder_dmem_we = 4'b0011;
        imem_ready = 1'b1;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            dmem_ready = (i == 4);
            #1;
            checks++;
            if (dmem_we !== 4'b0011 || dmem_rd !== 1'b0 || pc_we !== 1'b0) begin
                errors++;
                $display("FAIL store_mem_c%0d got dmem_we=%b dmem_rd=%0b pc_we=%0b exp 0011/0/0", i, dmem_we, dmem_rd, pc_we);
            end
            step();
        end
        dmem_ready = 1'b0;
        #1;
        checks++;
        if (pc_we !== 1'b1 || rf_we !== 1'b0 || dmem_we !== 4'b0000) begin
            errors++;
            $display("FAIL store_wb got pc_we=%0b rf_we=%0b dmem_we=%b exp 1/0/0000", pc_we, rf_we, dmem_we);
        end
        step();
        checks++;
        if (instret_cnt !== 32'd1 || cycle_cnt !== 32'd8) begin
            errors++;
            $display("FAIL store_counters got instret=%0d cyc=%0d exp 1/8", instret_cnt, cycle_cnt);
        end
        $display("test_store done");
    endtask

    task automatic test_imem_timeout();
        reset_dut();
        is_ALU = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #1;
            checks++;
            if (imem_rd !== 1'b1 || trap !== 1'b0) begin
                errors++;
                $display("FAIL imem_wait_c%0d got imem_rd=%0b trap=%0b exp 1/0", i, imem_rd, trap);
            end
            step();
        end
        checks++;
        if (trap !== 1'b1 || trap_cause !== 2'b10 || imem_rd !== 1'b0) begin
            errors++;
            $display("FAIL imem_timeout got trap=%0b cause=%b imem_rd=%0b exp 1/10/0", trap, trap_cause, imem_rd);
        end
        checks++;
        if (cycle_cnt !== 32'd9) begin
            errors++;
            $display("FAIL imem_timeout_cyc got %0d exp 9", cycle_cnt);
        end
        imem_ready = 1'b1;
        step();
        step();
        step();
        checks++;
        if (trap !== 1'b1 || cycle_cnt !== 32'd9 || imem_rd !== 1'b0) begin
            errors++;
            $display("FAIL imem_timeout_frozen got trap=%0b cyc=%0d imem_rd=%0b exp 1/9/0", trap, cycle_cnt, imem_rd);
        end
        $display("test_imem_timeout done");
    endtask

    task automatic test_imem_ready_at_limit();
        reset_dut();
        is_ALU = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
        end
        imem_ready = 1'b1;
        #1;
        step();
        checks++;
        if (trap !== 1'b0 || imem_rd !== 1'b0 || trap_cause !== 2'b00) begin
            errors++;
            $display("FAIL ready_at_limit got trap=%0b imem_rd=%0b cause=%b exp 0/0/00", trap, imem_rd, trap_cause);
        end
        step();
        checks++;
        if (pc_we !== 1'b1 || rf_we !== 1'b1) begin
            errors++;
            $display("FAIL ready_at_limit_wb got pc_we=%0b rf_we=%0b exp 1/1", pc_we, rf_we);
        end
        $display("test_imem_ready_at_limit done");
    endtask

    task automatic test_illegal();
        reset_dut();
        imem_ready = 1'b1;
        step();
        step();
        checks++;
        if (trap !== 1'b1 || trap_cause !== 2'b01 || cycle_cnt !== 32'd2) begin
            errors++;
            $display("FAIL illegal_trap got trap=%0b cause=%b cyc=%0d exp 1/01/2", trap, trap_cause, cycle_cnt);
        end
        is_ALU = 1'b1;
        resume = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({pc_we, imem_rd, rf_we, dmem_rd, dmem_we, halted} !== 9'd0 || trap !== 1'b1 || trap_cause !== 2'b01) begin
                errors++;
                $display("FAIL illegal_hold_%0d got en=%b trap=%0b cause=%b exp 0/1/01", i,
                         {pc_we, imem_rd, rf_we, dmem_rd, dmem_we, halted}, trap, trap_cause);
            end
        end
        $display("test_illegal done");
    endtask

    task automatic test_halt_resume();
        reset_dut();
        is_SYSTEM = 1'b1;
        imem_ready = 1'b1;
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (halted !== 1'b1 || pc_we !== 1'b0 || imem_rd !== 1'b0) begin
                errors++;
                $display("FAIL halt_c%0d got halted=%0b pc_we=%0b imem_rd=%0b exp 1/0/0", i, halted, pc_we, imem_rd);
            end
            step();
        end
        resume = 1'b1;
        step();
        resume = 1'b0;
        #1;
        checks++;
        if (pc_we !== 1'b1 || rf_we !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL resume_wb got pc_we=%0b rf_we=%0b halted=%0b exp 1/0/0", pc_we, rf_we, halted);
        end
        step();
        checks++;
        if (imem_rd !== 1'b1 || instret_cnt !== 32'd1 || cycle_cnt !== 32'd3) begin
            errors++;
            $display("FAIL resume_after got imem_rd=%0b instret=%0d cyc=%0d exp 1/1/3", imem_rd, instret_cnt, cycle_cnt);
        end
        $display("test_halt_resume done");
    endtask

    task automatic test_rst_mid_mem();
        reset_dut();
        is_LOAD = 1'b1;
        imem_ready = 1'b1;
        step();
        step();
        checks++;
        if (dmem_rd !== 1'b1 || dmem_we !== 4'b0000) begin
            errors++;
            $display("FAIL load_mem got dmem_rd=%0b dmem_we=%b exp 1/0000", dmem_rd, dmem_we);
        end
        step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (dmem_rd !== 1'b0 || cycle_cnt !== 32'd0 || pc_we !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_mem got dmem_rd=%0b cyc=%0d pc_we=%0b exp 0/0/0", dmem_rd, cycle_cnt, pc_we);
        end
        dmem_ready = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (imem_rd !== 1'b1 || dmem_rd !== 1'b0 || instret_cnt !== 32'd0 || cycle_cnt !== 32'd0 || trap_cause !== 2'b00) begin
            errors++;
            $display("FAIL rst_release got imem_rd=%0b dmem_rd=%0b instret=%0d cyc=%0d cause=%b exp 1/0/0/0/00",
                     imem_rd, dmem_rd, instret_cnt, cycle_cnt, trap_cause);
        end
        $display("test_rst_mid_mem done");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_store();
        test_imem_timeout();
        test_imem_ready_at_limit();
        test_illegal();
        test_halt_resume();
        test_rst_mid_mem();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
